// File: rtl/uart_pkg.sv
// Shared USART definitions: transmit-feeder FSM states and guard timing.
package uart_pkg;

  typedef enum logic [1:0] {
    TXF_IDLE  = 2'd0,
    TXF_WRITE = 2'd1,
    TXF_GUARD = 2'd2
  } txf_state_e;

  // UDRE takes two cycles to fall after a UDR write, so it is ignored that long.
  localparam int unsigned TXF_GUARD_CYC = 2;
  localparam int unsigned TXF_GUARD_W   = $clog2(TXF_GUARD_CYC + 1);

endpackage

// File: rtl/uart_tx_fifo_core.sv
// Circular byte buffer for the transmit feeder.
// Handles push/pop/flush arbitration and sticky overflow detection.
module uart_tx_fifo_core #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  input  logic             i_flush,
  input  logic             i_clr_overflow,
  output logic [WIDTH-1:0] o_head,
  output logic [AW:0]      o_count,
  output logic             o_full,
  output logic             o_empty,
  output logic             o_overflow
);

  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             pop_ok;
  logic             push_ok;
  logic             push_drop;

  assign o_full  = (o_count == FULL_CNT);
  assign o_empty = (o_count == '0);
  assign o_head  = mem[rd_ptr];

  // A pop on the same edge frees a slot, so a full FIFO can still accept a push.
  // Flush swallows a concurrent push without flagging it as an overflow.
  assign pop_ok    = i_pop && !o_empty && !i_flush;
  assign push_ok   = i_push && !i_flush && (!o_full || pop_ok);
  assign push_drop = i_push && !i_flush && !push_ok;

  // NOTE: storage is not reset; pointers and count define which entries are valid,
  // and leaving the array unreset lets it map onto plain RAM/flops without reset fan-out.
  always_ff @(posedge i_clk) begin
    if (push_ok) mem[wr_ptr] <= i_push_data;
  end

  // NOTE: all state here uses non-blocking assignments so every read in this block
  // sees the pre-edge value, exactly as the hardware registers would.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      o_count    <= '0;
      o_overflow <= 1'b0;
    end else begin
      if (i_flush) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        o_count <= '0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
        if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
        if (push_ok && !pop_ok)      o_count <= o_count + CNT_ONE;
        else if (pop_ok && !push_ok) o_count <= o_count - CNT_ONE;
      end
      if (push_drop)           o_overflow <= 1'b1;
      else if (i_clr_overflow) o_overflow <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_tx_feeder.sv
// Transmit feeder: queues producer bytes and strobes them into the USART UDR
// one at a time, only while UDRE reports empty and TXEN is set.
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_flush,
  input  logic             i_clr_overflow,
  input  logic             i_udre,
  input  logic             i_txen,
  output logic             o_we,
  output logic             o_udr_select,
  output logic [WIDTH-1:0] o_udr,
  output logic             o_full,
  output logic             o_empty,
  output logic [AW:0]      o_level,
  output logic             o_overflow
);

  localparam logic [TXF_GUARD_W-1:0] GUARD_LOAD = TXF_GUARD_W'(TXF_GUARD_CYC);
  localparam logic [TXF_GUARD_W-1:0] GUARD_ONE  = TXF_GUARD_W'(1);

  txf_state_e             state;
  logic [TXF_GUARD_W-1:0] guard_cnt;
  logic [WIDTH-1:0]       head;
  logic                   start;

  assign start        = (state == TXF_IDLE) && !o_empty && i_udre && i_txen && !i_flush;
  assign o_udr_select = o_we;

  uart_tx_fifo_core #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_fifo (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_push        (i_push),
    .i_push_data   (i_push_data),
    .i_pop         (start),
    .i_flush       (i_flush),
    .i_clr_overflow(i_clr_overflow),
    .o_head        (head),
    .o_count       (o_level),
    .o_full        (o_full),
    .o_empty       (o_empty),
    .o_overflow    (o_overflow)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= TXF_IDLE;
      guard_cnt <= '0;
      o_we      <= 1'b0;
      o_udr     <= '0;
    end else begin
      o_we <= 1'b0;
      case (state)
        TXF_IDLE: begin
          if (start) begin
            state <= TXF_WRITE;
            o_we  <= 1'b1;
            o_udr <= head;
          end
        end
        TXF_WRITE: begin
          state     <= TXF_GUARD;
          guard_cnt <= GUARD_LOAD;
        end
        TXF_GUARD: begin
          // Leave on the edge where the counter reaches zero, so UDRE is
          // sampled again in IDLE exactly TXF_GUARD_CYC+1 cycles after WRITE.
          guard_cnt <= guard_cnt - GUARD_ONE;
          if (guard_cnt == GUARD_ONE) state <= TXF_IDLE;
        end
        default: state <= TXF_IDLE;
      endcase
    end
  end

endmodule

// File: doc/uart_tx_feeder.md
# uart_tx_feeder

Transmit-side buffer that sits directly upstream of the USART register interface. Collects bytes pushed by the MCU-side producer into a small FIFO and drains them into the USART's UDR one at a time. Each drain is a one-cycle `we`+`udr_select` write strobe, issued only when UDRE reports the transmit buffer empty and the transmitter is enabled. Decouples bursty producers from the baud-rate-limited transmitter.

## Interface
Parameters:
- `WIDTH`, 8, data width; matches UDR width.
- `DEPTH`, 4, FIFO entries; power of two, ≥2.
- `AW`, $clog2(DEPTH), pointer width.

Ports:
- `i_clk` in 1: single clock, same domain as the USART register block.
- `i_rst` in 1: reset, synchronous and active-high.
- `i_push` in 1: producer write strobe.
- `i_push_data` in WIDTH: byte to enqueue.
- `i_flush` in 1: discard all queued bytes.
- `i_clr_overflow` in 1: clears `o_overflow`.
- `i_udre` in 1: UDRE flag (UCSRA bit 5) from the USART.
- `i_txen` in 1: TXEN (UCSRB bit 3) from the USART.
- `o_we` out 1: USART write enable.
- `o_udr_select` out 1: USART UDR select; always equal to `o_we`.
- `o_udr` out WIDTH: data driven to USART UDR input.
- `o_full` out 1: level == DEPTH.
- `o_empty` out 1: level == 0.
- `o_level` out AW+1: entries currently queued.
- `o_overflow` out 1: sticky; a push was dropped.

## Operation
- Storage: circular buffer with `wr_ptr` and `rd_ptr` (AW bits) and `count` (AW+1 bits). Pointers wrap from DEPTH-1 to 0.
- Push is accepted when `i_push` is high and (count < DEPTH, or a pop occurs in the same cycle).
  - Push rejected because the FIFO is full: data is dropped and `o_overflow` sets.
- FSM states are IDLE, WRITE and GUARD.
  - IDLE → WRITE when !empty & `i_udre` & `i_txen` & !`i_flush`. On that edge: pop the head into the `o_udr` register, advance `rd_ptr`, decrement count.
  - WRITE: `o_we` = `o_udr_select` = 1 for exactly one cycle. Next state is GUARD, with the guard counter loaded with 2.
  - GUARD: `i_udre` is ignored. This covers the two-cycle latency before UDRE falls after a UDR write. The counter decrements each cycle; at 0 the FSM goes to IDLE.
- `i_txen` low: no new drain starts. Any WRITE/GUARD already in progress completes. Queued data is retained.
- `i_flush`: on the next edge, pointers and count go to 0.
  - A write in WRITE/GUARD completes, because its byte was already popped.
  - Flush and push in the same cycle: flush wins, the push is dropped, and `o_overflow` is not set.
- `o_overflow` has two controls in the same cycle. Set takes priority over `i_clr_overflow`.
- Width rules:
  - `o_level` = `count` (AW+1 bits, range 0..DEPTH).
  - Simultaneous push and pop leaves count unchanged. Count never exceeds DEPTH or drops below 0.

## Timing
- Reset values:
  - `o_we`, `o_udr_select`, `o_overflow` = 0; `o_udr` = 0.
  - `o_level` = 0, `o_empty` = 1, `o_full` = 0.
  - FSM = IDLE, pointers = 0.
- Reset asserted mid-operation aborts WRITE/GUARD. Outputs return to reset values on the next edge.
- All outputs are registered or decoded from registers only. There is no combinational path from inputs to outputs.
- Latency, starting from a push at edge N into an empty FIFO in IDLE with `i_udre`=`i_txen`=1:
  - entry is visible after edge N+1;
  - FSM enters WRITE after edge N+2, so `o_we` is high during cycle N+2;
  - UDRE is next sampled in IDLE 3 cycles after WRITE.
- Back-to-back throughput is bounded by one write per 4 cycles, plus whatever time UDRE stays low.
- Pop occurs only on the IDLE→WRITE edge. A push and that pop on the same edge when full: both are accepted and count stays DEPTH.

## Structure
- Shared package `uart_pkg`:
  - FSM state localparams `TXF_IDLE`, `TXF_WRITE`, `TXF_GUARD`;
  - guard length constant `TXF_GUARD_CYC` = 2.
- One sub-module, `uart_tx_fifo_core`. It holds storage, pointers, count, full/empty, push/pop/flush arbitration and overflow detection.
- The top level contains the FSM, the guard counter and the output registers.

## Test plan
- Reset → check all outputs at reset values. Push 0xA5 with UDRE=1 and TXEN=1 → `o_we` pulses for exactly 1 cycle, 2 cycles after the push, with `o_udr`=0xA5. Level returns to 0.
- TXEN=0, push 0x01..0x04 → `o_full`=1, `o_level`=4, no `o_we`. Push 0x05 → dropped, `o_overflow`=1. TXEN=1 → writes 0x01..0x04 in order. `i_clr_overflow` → `o_overflow`=0.
- Hold UDRE=0 with 3 entries queued → no writes. Raise UDRE → one write, then GUARD blocks for 2 cycles even though UDRE is still 1. Lower UDRE in GUARD → the next write waits for UDRE to return high.
- FIFO full and FSM leaving IDLE, push 0x77 in the same cycle → accepted, level stays 4, no overflow. 0x77 later appears as the 4th write.
- Assert `i_flush` during WRITE of 0x10 with 0x11 and 0x12 queued → 0x10 write completes, level=0, 0x11 and 0x12 are never written. Flush together with push → level 0, no overflow.
- Assert `i_rst` during GUARD → next cycle: FSM in IDLE, `o_we`=0, level=0, `o_udr`=0.
